// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial bit-sequence detector with
// selectable overlap, registered match pulse and saturating hit counter.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic               cfg_we_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               overlap_en_i,
    input  logic               dato_valid_i,
    input  logic               dato_i,
    input  logic               hit_clr_i,
    output logic               detectada_o,
    output logic [CNT_W-1:0]   hit_count_o,
    output logic               armed_o,
    output logic               cfg_err_o
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d, hist_q, hist_d, hist_n, mask;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_n;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, det_d, err_q, err_d, len_ok, sample, match;
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            det_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            det_q     <= det_d;
            err_q     <= err_d;
        end
    end
    // A config strobe always wins over a sample arriving on the same edge.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        err_d     = 1'b0;
        len_ok    = cfg_len_i != '0 && cfg_len_i <= MAX_L;
        sample    = state_q == RUN && dato_valid_i && !cfg_we_i;
        hist_n    = {hist_q[MAX_LEN-2:0], dato_i};
        fill_n    = fill_q == MAX_L ? fill_q : fill_q + 1'b1;
        mask      = ~({MAX_LEN{1'b1}} << len_q);
        match     = sample && fill_n >= len_q && ((hist_n ^ pattern_q) & mask) == '0;
        det_d     = match;
        if (cfg_we_i) begin
            err_d = !len_ok;
            if (len_ok) begin
                state_d   = RUN;
                pattern_d = cfg_pattern_i;
                len_d     = cfg_len_i;
                hist_d    = '0;
                fill_d    = '0;
            end
        end else if (sample) begin
            hist_d = match && !overlap_en_i ? '0 : hist_n;
            fill_d = match && !overlap_en_i ? '0 : fill_n;
        end
        cnt_d = hit_clr_i ? (match ? CNT_W'(1) : '0)
              : (match && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q);
    end
    assign detectada_o = det_q;
    assign hit_count_o = cnt_q;
    assign armed_o     = state_q == RUN;
    assign cfg_err_o   = err_q;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed scoreboard bench; a second instance with a
// 2-bit counter exercises hit_count saturation.
module tb_seq_detector_prog;
    logic       clk_2 = 0, reset = 1;
    logic       cfg_we = 0, overlap_en = 0, dato_valid = 0, dato = 0, hit_clr = 0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       det0, armed0, err0, det1, armed1, err1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    int         total = 0, bad = 0;
    logic       exp_q[$];

    seq_detector_prog u0 (
        .clk_2(clk_2), .reset(reset), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .overlap_en_i(overlap_en), .dato_valid_i(dato_valid),
        .dato_i(dato), .hit_clr_i(hit_clr), .detectada_o(det0), .hit_count_o(cnt0),
        .armed_o(armed0), .cfg_err_o(err0));

    seq_detector_prog #(.CNT_W(2)) u1 (
        .clk_2(clk_2), .reset(reset), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .overlap_en_i(overlap_en), .dato_valid_i(dato_valid),
        .dato_i(dato), .hit_clr_i(hit_clr), .detectada_o(det1), .hit_count_o(cnt1),
        .armed_o(armed1), .cfg_err_o(err1));

    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic v, input logic d, input logic e);
        dato_valid = v;
        dato = d;
        exp_q.push_back(e);
        tick();
        chk("det", det0, exp_q.pop_front());
        dato_valid = 0;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic err_exp, input logic armed_exp);
        cfg_we = 1;
        cfg_pattern = p;
        cfg_len = l;
        tick();
        cfg_we = 0;
        chk("cfg_err", err0, err_exp);
        chk("armed", armed0, armed_exp);
    endtask

    task automatic clr();
        hit_clr = 1;
        tick();
        hit_clr = 0;
        chk("clr0", cnt0, 0);
        chk("clr1", cnt1, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_det", det0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_armed", armed0, 0);
        chk("rst_err", err0, 0);
        reset = 0;
        send(1, 1, 0);
        send(1, 1, 0);
        chk("idle_armed", armed0, 0);

        // T2: overlapping 1101
        overlap_en = 1;
        cfg(8'b1101, 4, 0, 1);
        send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);
        send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);
        chk("t2_cnt", cnt0, 2);
        send(0, 0, 0);

        // T3: non-overlapping, same stream
        overlap_en = 0;
        cfg(8'b1101, 4, 0, 1);
        clr();
        send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);
        send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
        chk("t3_cnt", cnt0, 1);

        // T4: illegal lengths leave config and history intact
        cfg(8'hff, 0, 1, 1);
        tick();
        chk("err_pulse", err0, 0);
        cfg(8'hff, 9, 1, 1);
        send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);
        overlap_en = 1;
        cfg(8'b1, 1, 0, 1);
        send(1, 1, 1); send(1, 1, 1); send(1, 0, 0); send(1, 1, 1);

        // cfg_we discards a coincident sample
        dato_valid = 1;
        dato = 1;
        cfg(8'b1101, 4, 0, 1);
        send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
        send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);

        // T5: gaps of 3 idle cycles between bits
        overlap_en = 0;
        cfg(8'b1101, 4, 0, 1);
        send(1, 1, 0); send(0, 0, 0); send(0, 1, 0); send(0, 0, 0);
        send(1, 1, 0); send(0, 0, 0); send(0, 0, 0); send(0, 1, 0);
        send(1, 0, 0); send(0, 1, 0); send(0, 0, 0); send(0, 0, 0);
        send(1, 1, 1); send(0, 1, 0); send(0, 0, 0);

        // T6: saturation on the 2-bit counter, clear coincident with match
        overlap_en = 1;
        cfg(8'b1, 1, 0, 1);
        clr();
        for (int i = 0; i < 5; i++) send(1, 1, 1);
        chk("sat1", cnt1, 3);
        chk("cnt0_5", cnt0, 5);
        hit_clr = 1;
        send(1, 1, 1);
        hit_clr = 0;
        chk("clr_match0", cnt0, 1);
        chk("clr_match1", cnt1, 1);

        // T1: async reset mid-run with a partial match pending
        cfg(8'b1101, 4, 0, 1);
        send(1, 1, 0); send(1, 1, 0); send(1, 0, 0);
        #2 reset = 1;
        #1;
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_armed", armed0, 0);
        chk("mid_rst_det", det0, 0);
        tick();
        reset = 0;
        send(1, 1, 0);
        chk("post_rst_armed", armed0, 0);
        cfg(8'b1101, 4, 0, 1);
        send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
        chk("post_rst_cnt", cnt0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
